// File: rtl/shift_arbiter_if.sv
// ---------------------------------------------------------------------------
// shift_arbiter_if
//
// Bundles the request and response handshakes of shift_arbiter.
//
//   req_valid_i  [NUM_REQ]        per-requester request valid
//   req_ready_o  [NUM_REQ]        per-requester accept (at most one set)
//   req_val_i    [NUM_REQ*WIDTH]  operands, requester k at [k*WIDTH +: WIDTH]
//   req_shift_i  [NUM_REQ*SHW]    shift amounts, requester k at [k*SHW +: SHW]
//   resp_valid_o                  output stage holds a result
//   resp_ready_i                  consumer accepts the result
//   resp_data_o  [WIDTH]          shifted result
//   resp_id_o    [IDW]            requester that produced resp_data_o
//   busy_cnt_o   [16]             saturating count of stalled-request cycles
//
// Signal names keep the direction suffix as seen from the arbiter.
// master: requesters/consumer side. slave: the arbiter.
// ---------------------------------------------------------------------------
interface shift_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHW     = 6,
    parameter int unsigned IDW     = 2
) ();

    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ*WIDTH-1:0] req_val_i;
    logic [NUM_REQ*SHW-1:0]   req_shift_i;
    logic                     resp_valid_o;
    logic                     resp_ready_i;
    logic [WIDTH-1:0]         resp_data_o;
    logic [IDW-1:0]           resp_id_o;
    logic [15:0]              busy_cnt_o;

    modport master (
        output req_valid_i,
        input  req_ready_o,
        output req_val_i,
        output req_shift_i,
        input  resp_valid_o,
        output resp_ready_i,
        input  resp_data_o,
        input  resp_id_o,
        input  busy_cnt_o
    );

    modport slave (
        input  req_valid_i,
        output req_ready_o,
        input  req_val_i,
        input  req_shift_i,
        output resp_valid_o,
        input  resp_ready_i,
        output resp_data_o,
        output resp_id_o,
        output busy_cnt_o
    );

endinterface

// File: rtl/shift_arbiter.sv
// ---------------------------------------------------------------------------
// shift_arbiter
//
// Shares one logical-left-shift datapath among NUM_REQ requesters. A
// round-robin arbiter picks one valid requester per cycle; its shifted
// operand is registered into a single-entry output stage.
//
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   reset_i  synchronous active-high reset
//   bus      shift_arbiter_if.slave: request valid/ready/operand/shift per
//            requester, response valid/ready/data/id, busy cycle counter
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   WIDTH    operand/result width
//   SHW      shift-amount width; amounts >= WIDTH produce zero
//   IDW      requester-id width, >= clog2(NUM_REQ)
// ---------------------------------------------------------------------------
module shift_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHW     = 6,
    parameter int unsigned IDW     = 2
) (
    input  logic           clk_i,
    input  logic           reset_i,
    shift_arbiter_if.slave bus
);

    // One extra bit so rr + offset never overflows before the wrap.
    localparam int unsigned CW = IDW + 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : gen_bad_num_req
        $error("shift_arbiter: NUM_REQ must be in 2..8");
    end
    if (IDW < $clog2(NUM_REQ)) begin : gen_bad_idw
        $error("shift_arbiter: IDW too narrow for NUM_REQ");
    end

    // State
    logic [IDW-1:0]   rr_q, rr_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic [IDW-1:0]   resp_id_q, resp_id_d;
    logic [15:0]      busy_cnt_q, busy_cnt_d;

    // Arbitration and datapath
    logic [CW-1:0]      cand;
    logic               found;
    logic [IDW-1:0]     grant;
    logic               slot_free;
    logic               accept;
    logic [NUM_REQ-1:0] req_ready;
    logic [WIDTH-1:0]   sel_val;
    logic [SHW-1:0]     sel_shift;
    logic [WIDTH-1:0]   shifted;

    // A result may be replaced in the same cycle it drains.
    assign slot_free = !resp_valid_q || bus.resp_ready_i;

    // Round-robin scan starting at rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        cand  = '0;
        found = 1'b0;
        grant = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_q} + CW'(i);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!found && bus.req_valid_i[cand[IDW-1:0]]) begin
                found = 1'b1;
                grant = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found && slot_free) begin
            req_ready[grant] = 1'b1;
        end
    end

    // The grant is valid by construction, so accept needs no extra valid term.
    assign accept = found && slot_free;

    // Operand and amount mux for the granted requester.
    always_comb begin
        sel_val   = '0;
        sel_shift = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant == IDW'(k)) begin
                sel_val   = bus.req_val_i[k*WIDTH +: WIDTH];
                sel_shift = bus.req_shift_i[k*SHW +: SHW];
            end
        end
    end

    // Out-of-range amounts are forced to zero explicitly rather than relying
    // on shift-operator semantics.
    always_comb begin
        if (32'(sel_shift) >= WIDTH) begin
            shifted = '0;
        end else begin
            shifted = sel_val << sel_shift;
        end
    end

    // Next-state
    always_comb begin
        rr_d         = rr_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        busy_cnt_d   = busy_cnt_q;

        if (accept) begin
            resp_valid_d = 1'b1;
            resp_data_d  = shifted;
            resp_id_d    = grant;
            rr_d         = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + IDW'(1);
        end else if (resp_valid_q && bus.resp_ready_i) begin
            // Drain only; data and id keep their last values.
            resp_valid_d = 1'b0;
        end

        if ((|bus.req_valid_i) && !accept && (busy_cnt_q != 16'hFFFF)) begin
            busy_cnt_d = busy_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            busy_cnt_q   <= '0;
        end else begin
            rr_q         <= rr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            busy_cnt_q   <= busy_cnt_d;
        end
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_data_o  = resp_data_q;
    assign bus.resp_id_o    = resp_id_q;
    assign bus.busy_cnt_o   = busy_cnt_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shift_arbiter
//
// Scenario tasks drive requests and check specific outputs inline. A negedge
// monitor keeps a reference model of the arbiter: it predicts req_ready_o,
// resp_valid_o and busy_cnt_o every cycle and pushes the expected result of
// every predicted accept onto a scoreboard, popped when the DUT drains it.
// ---------------------------------------------------------------------------
module tb_shift_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHW     = 6;
    localparam int unsigned IDW     = 2;

    logic clk = 1'b0;
    logic reset_i;

    always #5 clk = ~clk;

    shift_arbiter_if #(
        .NUM_REQ(NUM_REQ),
        .WIDTH  (WIDTH),
        .SHW    (SHW),
        .IDW    (IDW)
    ) bus ();

    shift_arbiter #(
        .NUM_REQ(NUM_REQ),
        .WIDTH  (WIDTH),
        .SHW    (SHW),
        .IDW    (IDW)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
    } resp_t;

    resp_t sb[$];

    // Reference model state
    int          m_rr;
    logic        m_valid;
    logic [15:0] m_busy;
    int          m_g;
    logic        m_found;
    logic        m_slot;
    logic [NUM_REQ-1:0] m_rdy;
    resp_t       m_e;
    resp_t       m_got;

    function automatic logic [WIDTH-1:0] ref_shift(logic [WIDTH-1:0] v, logic [SHW-1:0] s);
        if (int'(s) >= int'(WIDTH)) return '0;
        return v << s;
    endfunction

    always @(negedge clk) begin : monitor
        if (reset_i) begin
            m_rr    = 0;
            m_valid = 1'b0;
            m_busy  = 16'd0;
            sb.delete();
        end else begin
            m_slot  = !m_valid || bus.resp_ready_i;
            m_found = 1'b0;
            m_g     = 0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                int idx;
                idx = (m_rr + i) % int'(NUM_REQ);
                if (!m_found && bus.req_valid_i[idx]) begin
                    m_found = 1'b1;
                    m_g     = idx;
                end
            end
            m_rdy = '0;
            if (m_found && m_slot) m_rdy[m_g] = 1'b1;

            checks++;
            if (bus.req_ready_o !== m_rdy) begin
                errors++;
                $display("FAIL mon_req_ready t=%0t got=%b exp=%b", $time, bus.req_ready_o, m_rdy);
            end
            checks++;
            if (bus.resp_valid_o !== m_valid) begin
                errors++;
                $display("FAIL mon_resp_valid t=%0t got=%b exp=%b", $time, bus.resp_valid_o,
                         m_valid);
            end
            checks++;
            if (bus.busy_cnt_o !== m_busy) begin
                errors++;
                $display("FAIL mon_busy_cnt t=%0t got=%0d exp=%0d", $time, bus.busy_cnt_o, m_busy);
            end

            if (bus.resp_valid_o === 1'b1 && bus.resp_ready_i === 1'b1) begin
                checks++;
                m_got.id   = bus.resp_id_o;
                m_got.data = bus.resp_data_o;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected t=%0t got id=%0d data=%h exp=none", $time,
                             m_got.id, m_got.data);
                end else begin
                    m_e = sb.pop_front();
                    if (m_got !== m_e) begin
                        errors++;
                        $display("FAIL sb_result t=%0t got id=%0d data=%h exp id=%0d data=%h",
                                 $time, m_got.id, m_got.data, m_e.id, m_e.data);
                    end
                end
            end

            if (m_found && m_slot) begin
                m_e.id   = IDW'(m_g);
                m_e.data = ref_shift(bus.req_val_i[m_g*WIDTH +: WIDTH],
                                     bus.req_shift_i[m_g*SHW +: SHW]);
                sb.push_back(m_e);
                m_rr    = (m_g + 1) % int'(NUM_REQ);
                m_valid = 1'b1;
            end else if (m_valid && bus.resp_ready_i) begin
                m_valid = 1'b0;
            end
            if ((|bus.req_valid_i) && !(m_found && m_slot) && m_busy != 16'hFFFF) begin
                m_busy = m_busy + 16'd1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int k, logic [WIDTH-1:0] v, logic [SHW-1:0] s);
        bus.req_val_i[k*WIDTH +: WIDTH] = v;
        bus.req_shift_i[k*SHW +: SHW]   = s;
        bus.req_valid_i[k]              = 1'b1;
    endtask

    task automatic clr_req(int k);
        bus.req_valid_i[k] = 1'b0;
    endtask

    task automatic chk_resp(string name, logic exp_v, logic [WIDTH-1:0] exp_d,
                            logic [IDW-1:0] exp_id);
        // Inline checks of the output stage at the current negedge.
        checks++;
        if (bus.resp_valid_o !== exp_v) begin
            errors++;
            $display("FAIL %s_valid got=%b exp=%b", name, bus.resp_valid_o, exp_v);
        end
        checks++;
        if (bus.resp_data_o !== exp_d) begin
            errors++;
            $display("FAIL %s_data got=%h exp=%h", name, bus.resp_data_o, exp_d);
        end
        checks++;
        if (bus.resp_id_o !== exp_id) begin
            errors++;
            $display("FAIL %s_id got=%0d exp=%0d", name, bus.resp_id_o, exp_id);
        end
    endtask

    task automatic test_reset();
        reset_i          = 1'b1;
        bus.req_valid_i  = '0;
        bus.req_val_i    = '0;
        bus.req_shift_i  = '0;
        bus.resp_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        chk_resp("reset", 1'b0, '0, '0);
        checks++;
        if (bus.busy_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_busy got=%0d exp=0", bus.busy_cnt_o);
        end
        checks++;
        if (bus.req_ready_o !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=0000", bus.req_ready_o);
        end
        step();
    endtask

    task automatic test_single();
        set_req(0, 32'h0000_00F1, 6'd4);
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready got=%b exp=0001", bus.req_ready_o);
        end
        step();
        clr_req(0);
        @(negedge clk);
        chk_resp("single", 1'b1, 32'h0000_0F10, 2'd0);
        step();
        @(negedge clk);
        checks++;
        if (bus.resp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_drain got=%b exp=0", bus.resp_valid_o);
        end
        step();
    endtask

    task automatic test_shift_bounds();
        logic [WIDTH-1:0] vals [4] = '{32'hDEAD_BEEF, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [SHW-1:0]   shs  [4] = '{6'd0, 6'd31, 6'd32, 6'd63};
        logic [WIDTH-1:0] exps [4] = '{32'hDEAD_BEEF, 32'h8000_0000, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            set_req(2, vals[i], shs[i]);
            step();
            clr_req(2);
            @(negedge clk);
            chk_resp($sformatf("shift%0d", shs[i]), 1'b1, exps[i], 2'd2);
            step();
        end
    endtask

    task automatic test_round_robin();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(k, 32'h0101_0101 * (k + 1), SHW'(k + 1));
        end
        bus.resp_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 7) bus.req_valid_i = '0;
            @(negedge clk);
            checks++;
            if (bus.resp_valid_o !== 1'b1 || bus.resp_id_o !== IDW'(k % 4)) begin
                errors++;
                $display("FAIL rr_seq%0d got valid=%b id=%0d exp valid=1 id=%0d", k,
                         bus.resp_valid_o, bus.resp_id_o, k % 4);
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        bus.resp_ready_i = 1'b0;
        set_req(0, 32'h0000_1234, 6'd8);
        step();
        clr_req(0);
        set_req(1, 32'hA5A5_0001, 6'd1);
        set_req(3, 32'h0000_FFFF, 6'd16);
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            chk_resp($sformatf("hold%0d", h), 1'b1, 32'h0012_3400, 2'd0);
            checks++;
            if (bus.req_ready_o !== 4'b0000 || bus.busy_cnt_o !== 16'(h)) begin
                errors++;
                $display("FAIL hold%0d_ready_busy got ready=%b busy=%0d exp ready=0000 busy=%0d",
                         h, bus.req_ready_o, bus.busy_cnt_o, h);
            end
            step();
        end
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready_o !== 4'b0010 || bus.busy_cnt_o !== 16'd3) begin
            errors++;
            $display("FAIL release got ready=%b busy=%0d exp ready=0010 busy=3",
                     bus.req_ready_o, bus.busy_cnt_o);
        end
        step();
        clr_req(1);
        @(negedge clk);
        chk_resp("bp_req1", 1'b1, 32'h4B4A_0002, 2'd1);
        step();
        clr_req(3);
        @(negedge clk);
        chk_resp("bp_req3", 1'b1, 32'hFFFF_0000, 2'd3);
        step();
    endtask

    task automatic test_priority();
        set_req(1, 32'h0000_0011, 6'd1);
        step();
        clr_req(1);
        set_req(0, 32'h0000_0022, 6'd2);
        @(negedge clk);
        checks++;
        if (bus.req_ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL prio_req0 got=%b exp=0001", bus.req_ready_o);
        end
        step();
        clr_req(0);
        set_req(1, 32'h0000_0033, 6'd3);
        set_req(3, 32'h0000_0044, 6'd4);
        @(negedge clk);
        checks++;
        if (bus.req_ready_o !== 4'b0010) begin
            errors++;
            $display("FAIL prio_req1 got=%b exp=0010", bus.req_ready_o);
        end
        step();
        clr_req(1);
        @(negedge clk);
        chk_resp("prio_r1", 1'b1, 32'h0000_0198, 2'd1);
        step();
        clr_req(3);
        @(negedge clk);
        chk_resp("prio_r3", 1'b1, 32'h0000_0440, 2'd3);
        step();
    endtask

    task automatic test_reset_mid();
        bus.resp_ready_i = 1'b0;
        set_req(2, 32'hCAFE_0001, 6'd4);
        step();
        clr_req(2);
        @(negedge clk);
        chk_resp("mid_hold", 1'b1, 32'hAFE0_0010, 2'd2);
        step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        set_req(2, 32'h0000_0005, 6'd1);
        set_req(0, 32'h0000_0007, 6'd2);
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        chk_resp("mid_reset", 1'b0, '0, '0);
        checks++;
        if (bus.req_ready_o !== 4'b0001 || bus.busy_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL mid_ready_busy got ready=%b busy=%0d exp ready=0001 busy=0",
                     bus.req_ready_o, bus.busy_cnt_o);
        end
        step();
        clr_req(0);
        @(negedge clk);
        chk_resp("mid_r0", 1'b1, 32'h0000_001C, 2'd0);
        step();
        clr_req(2);
        @(negedge clk);
        chk_resp("mid_r2", 1'b1, 32'h0000_000A, 2'd2);
        step();
        step();
        @(negedge clk);
        checks++;
        if (sb.size() != 0 || bus.resp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL final_drain got pending=%0d valid=%b exp pending=0 valid=0",
                     sb.size(), bus.resp_valid_o);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        test_reset();
        test_single();
        test_shift_bounds();
        test_round_robin();
        test_backpressure();
        test_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
